// File: rtl/cycle_timing_pkg.sv
// Shared clk32 memory-cycle timing definitions: lock-tracker states and the
// default cycle length used by all clk32 timing consumers.
package cycle_timing_pkg;

  // clk32 cycles per 2 MHz memory cycle
  localparam int CYCLE_LEN_DEFAULT = 16;
  localparam int PH_W = $clog2(CYCLE_LEN_DEFAULT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    SLIP   = 2'd3
  } cyc_state_t;

  // LOCKED and SLIP both count as "locked" to the outside world
  function automatic logic is_locked(input cyc_state_t s);
    return (s == LOCKED) || (s == SLIP);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones, never wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk32,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  // count up on inc until all-ones; clear has priority
  always_ff @(posedge clk32) begin
    if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/cycle_phase_tracker.sv
// Receive-side tracker for the clk32 cycle-timing strobes. Locks a local
// memory-cycle phase counter onto cycsel_en, reports lock and slot strobes,
// and counts timing violations in a saturating counter.
// Optional build macro: CYCLE_PHASE_ADDRSEL_CHECK_EN enables checking that
// addrsel rises exactly at phase ADDRSEL_PH while locked.
module cycle_phase_tracker
  import cycle_timing_pkg::*;
#(
  parameter int CYCLE_LEN  = CYCLE_LEN_DEFAULT,
  parameter int LOCK_CNT   = 4,
  parameter int MISS_MAX   = 2,
  parameter int ERR_W      = 8,
  parameter int ADDRSEL_PH = 6
) (
  input  logic                         clk32,
  input  logic                         reset,
  input  logic                         cycsel_en,
  input  logic                         addrsel,
  input  logic                         latch,
  output logic [$clog2(CYCLE_LEN)-1:0] phase,
  output logic                         locked,
  output logic                         slot_start,
  output logic                         phase_hit,
  output logic [ERR_W-1:0]             err_cnt
);

  localparam int PW = $clog2(CYCLE_LEN);
  localparam logic [PW-1:0] LAST_PH = PW'(CYCLE_LEN - 1);

  cyc_state_t    state_reg, state_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic [3:0]    good_reg, good_next;
  logic [2:0]    miss_reg, miss_next;
  logic          bad_reg, bad_next;      // violation already counted this cycle
  logic          slot_start_reg, phase_hit_reg;
  logic          err_inc;
  logic          addr_clear;             // restart per-cycle addrsel bookkeeping
  logic          addr_rise_bad;          // addrsel rose at the wrong phase this clock
  logic          addr_cyc_bad;           // addrsel timing wrong for the cycle ending now
  logic          end_ph, stray, locked_now;

  assign end_ph     = (phase_reg == LAST_PH);
  assign stray      = cycsel_en && !end_ph;
  assign locked_now = is_locked(state_reg);

`ifdef CYCLE_PHASE_ADDRSEL_CHECK_EN
  localparam logic [PW-1:0] ADDR_PH = PW'(ADDRSEL_PH);

  logic addr_prev_reg, addr_seen_reg, addr_wrong_reg;
  logic addr_rise, addr_rise_ok;

  assign addr_rise     = addrsel && !addr_prev_reg;
  assign addr_rise_ok  = addr_rise && (phase_reg == ADDR_PH);
  assign addr_rise_bad = addr_rise && !addr_rise_ok;
  assign addr_cyc_bad  = addr_wrong_reg || addr_rise_bad || !(addr_seen_reg || addr_rise_ok);

  // remember previous addrsel level and whether this cycle's rise was good/bad
  always_ff @(posedge clk32) begin
    if (reset) begin
      addr_prev_reg  <= 1'b0;
      addr_seen_reg  <= 1'b0;
      addr_wrong_reg <= 1'b0;
    end else begin
      addr_prev_reg <= addrsel;
      if (addr_clear) begin
        addr_seen_reg  <= 1'b0;
        addr_wrong_reg <= 1'b0;
      end else begin
        addr_seen_reg  <= addr_seen_reg || addr_rise_ok;
        addr_wrong_reg <= addr_wrong_reg || addr_rise_bad;
      end
    end
  end
`else
  logic unused_addr;
  assign unused_addr   = addrsel ^ addr_clear ^ (ADDRSEL_PH < 0);
  assign addr_rise_bad = 1'b0;
  assign addr_cyc_bad  = 1'b0;
`endif

  // next-state, phase and violation decisions
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg + 1'b1;
    good_next  = good_reg;
    miss_next  = miss_reg;
    bad_next   = end_ph ? 1'b0 : bad_reg;
    addr_clear = end_ph;
    err_inc    = 1'b0;
    case (state_reg)
      HUNT: begin
        phase_next = '0;
        bad_next   = 1'b0;
        addr_clear = 1'b1;
        if (cycsel_en) begin
          good_next  = 4'd1;
          state_next = (LOCK_CNT == 1) ? LOCKED : ACQ;
        end
      end
      ACQ: begin
        if (stray) begin
          // realign on the stray pulse and start counting again
          phase_next = '0;
          good_next  = 4'd1;
          addr_clear = 1'b1;
        end else if (end_ph) begin
          if (cycsel_en) begin
            good_next = good_reg + 4'd1;
            if (good_reg + 4'd1 == 4'(LOCK_CNT)) begin
              state_next = LOCKED;
            end
          end else begin
            state_next = HUNT;
            phase_next = '0;
            good_next  = '0;
          end
        end
      end
      LOCKED: begin
        if (stray || addr_rise_bad || (end_ph && (!cycsel_en || addr_cyc_bad))) begin
          err_inc = 1'b1;
          if (MISS_MAX == 1) begin
            state_next = HUNT;
            phase_next = '0;
            miss_next  = '0;
            bad_next   = 1'b0;
            addr_clear = 1'b1;
          end else begin
            state_next = SLIP;
            miss_next  = 3'd1;
            bad_next   = !end_ph;
          end
        end
      end
      SLIP: begin
        // judged once at the end of each cycle; strays alone do not realign
        if (end_ph) begin
          if (cycsel_en && !addr_cyc_bad) begin
            state_next = LOCKED;
            miss_next  = '0;
          end else if (!bad_reg) begin
            err_inc = 1'b1;
            if (miss_reg + 3'd1 == 3'(MISS_MAX)) begin
              state_next = HUNT;
              phase_next = '0;
              miss_next  = '0;
            end else begin
              miss_next = miss_reg + 3'd1;
            end
          end
        end
      end
      default: begin
        state_next = HUNT;
        phase_next = '0;
      end
    endcase
  end

  // state, phase and registered strobe outputs
  always_ff @(posedge clk32) begin
    if (reset) begin
      state_reg      <= HUNT;
      phase_reg      <= '0;
      good_reg       <= '0;
      miss_reg       <= '0;
      bad_reg        <= 1'b0;
      slot_start_reg <= 1'b0;
      phase_hit_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      good_reg       <= good_next;
      miss_reg       <= miss_next;
      bad_reg        <= bad_next;
      slot_start_reg <= locked_now && (phase_reg == '0);
      phase_hit_reg  <= locked_now && end_ph && latch;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err (
    .clk32 (clk32),
    .clr   (reset),
    .inc   (err_inc),
    .count (err_cnt)
  );

  assign phase      = phase_reg;
  assign locked     = locked_now;
  assign slot_start = slot_start_reg;
  assign phase_hit  = phase_hit_reg;

endmodule

// File: tb/tb_cycle_phase_tracker.sv
// Directed bench for cycle_phase_tracker. A second instance with a 2-bit
// error counter shares all inputs to exercise saturation.
module tb_cycle_phase_tracker;

  logic       clk32 = 1'b0;
  logic       reset, cycsel_en, addrsel, latch;
  logic [3:0] phase, phase2;
  logic       locked, slot_start, phase_hit;
  logic       locked2, slot_start2, phase_hit2;
  logic [7:0] err_cnt;
  logic [1:0] err2;

  int total = 0;
  int bad   = 0;
  int slot_cnt, slot_ph, phase_mid, hit_last, exp_err;

  always #5 clk32 = ~clk32;

  cycle_phase_tracker dut (
    .clk32(clk32), .reset(reset), .cycsel_en(cycsel_en), .addrsel(addrsel),
    .latch(latch), .phase(phase), .locked(locked), .slot_start(slot_start),
    .phase_hit(phase_hit), .err_cnt(err_cnt)
  );

  cycle_phase_tracker #(.ERR_W(2)) dut2 (
    .clk32(clk32), .reset(reset), .cycsel_en(cycsel_en), .addrsel(addrsel),
    .latch(latch), .phase(phase2), .locked(locked2), .slot_start(slot_start2),
    .phase_hit(phase_hit2), .err_cnt(err2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  // one memory cycle; p is the phase the tracker sees at each sampling edge
  task automatic run_cycle(input logic [15:0] mask, input int addr_at);
    slot_cnt = 0;
    slot_ph  = -1;
    for (int p = 0; p < 16; p++) begin
      cycsel_en = mask[p];
      addrsel   = (addr_at >= 0) && (p >= addr_at) && (p < addr_at + 6);
      latch     = (p == 15);
      tick();
      if (slot_start) begin
        slot_cnt++;
        slot_ph = int'(phase);
      end
      if (p == 7) phase_mid = int'(phase);
    end
    hit_last  = int'(phase_hit);
    cycsel_en = 1'b0;
    latch     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cycsel_en = 1'b0; addrsel = 1'b0; latch = 1'b0;
    tick();
    tick();
    check("rst_phase", int'(phase), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_slot", int'(slot_start), 0);
    check("rst_hit", int'(phase_hit), 0);
    check("rst_err", int'(err_cnt), 0);
    check("rst_err2", int'(err2), 0);
    reset = 1'b0;

    // ideal strobe: lock on the 4th pulse
    for (int c = 0; c < 4; c++) begin
      run_cycle(16'h8000, 6);
      check($sformatf("lock_c%0d", c), int'(locked), (c == 3) ? 1 : 0);
    end
    check("lock_err", int'(err_cnt), 0);
    check("lock_phase", int'(phase), 0);
    check("lock_hit_pre", hit_last, 0);
    run_cycle(16'h8000, 6);
    check("slot_cnt", slot_cnt, 1);
    check("slot_ph", slot_ph, 1);
    check("hit_locked", hit_last, 1);
    check("phase_mid", phase_mid, 8);

    // one pulse delayed by 3 clocks
    run_cycle(16'h0000, 6);
    check("dly_err", int'(err_cnt), 1);
    check("dly_err2", int'(err2), 1);
    check("dly_locked", int'(locked), 1);
    run_cycle(16'h8004, 6);
    check("dly_rec_err", int'(err_cnt), 1);
    check("dly_rec_locked", int'(locked), 1);

    // strobe removed: two missing cycles drop lock
    run_cycle(16'h0000, 6);
    check("miss1_err", int'(err_cnt), 2);
    check("miss1_locked", int'(locked), 1);
    run_cycle(16'h0000, 6);
    check("miss2_err", int'(err_cnt), 3);
    check("miss2_err2", int'(err2), 3);
    check("miss2_locked", int'(locked), 0);
    check("miss2_phase", int'(phase), 0);
    run_cycle(16'h0000, 6);
    check("hunt_phase_mid", phase_mid, 0);
    check("hunt_slot", slot_cnt, 0);

    // relock, then stray pulse in LOCKED
    for (int c = 0; c < 4; c++) run_cycle(16'h8000, 6);
    check("relock", int'(locked), 1);
    check("relock_err", int'(err_cnt), 3);
    run_cycle(16'h8020, 6);
    check("stray_err", int'(err_cnt), 4);
    check("stray_err2_sat", int'(err2), 3);
    check("stray_locked", int'(locked), 1);
    run_cycle(16'h0000, 6);
    check("post_stray_err", int'(err_cnt), 5);
    check("post_stray_err2", int'(err2), 3);
    check("post_stray_locked", int'(locked), 1);
    run_cycle(16'h8000, 6);
    check("back_locked", int'(locked), 1);

    // addrsel rising one phase late
`ifdef CYCLE_PHASE_ADDRSEL_CHECK_EN
    exp_err = 6;
`else
    exp_err = 5;
`endif
    run_cycle(16'h8000, 7);
    check("addr_late_err", int'(err_cnt), exp_err);
    check("addr_late_locked", int'(locked), 1);
    run_cycle(16'h8000, 6);
    check("addr_ok_err", int'(err_cnt), exp_err);
    check("addr_ok_locked", int'(locked), 1);

    // reset at phase 9 while locked
    for (int p = 0; p < 9; p++) begin
      addrsel = (p >= 6);
      tick();
    end
    check("pre_rst_phase", int'(phase), 9);
    reset = 1'b1; cycsel_en = 1'b1; latch = 1'b1;
    tick();
    check("mid_rst_phase", int'(phase), 0);
    check("mid_rst_locked", int'(locked), 0);
    check("mid_rst_err", int'(err_cnt), 0);
    check("mid_rst_err2", int'(err2), 0);
    check("mid_rst_slot", int'(slot_start), 0);
    check("mid_rst_hit", int'(phase_hit), 0);
    reset = 1'b0; cycsel_en = 1'b0; latch = 1'b0; addrsel = 1'b0;

    // acquisition lost on a missing pulse
    run_cycle(16'h8000, 6);
    check("acq_locked", int'(locked), 0);
    run_cycle(16'h0000, 6);
    check("acq_phase_mid", phase_mid, 8);
    check("acq_drop_phase", int'(phase), 0);
    check("acq_no_err", int'(err_cnt), 0);
    run_cycle(16'h0000, 6);
    check("acq_hunt_mid", phase_mid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
